ram_access_arbiter: RTL and testbench
=====================================

// Module: ram_access_arbiter
// PURPOSE
//  Sequences every access to the 256x8 ram block and shares it between two requesters (port 0, port 1).
//  Latches one request, drives ram address/in/RW/enRAM for HOLD cycles, captures the read data,
//  and returns a one-cycle ack to the winner. Round-robin arbitration.
//  Sits between the ram instance and its clients; it is the only driver of the ram control inputs.
// PARAMETERS
//  ADDR_W  8  ram address width; ram depth is 2**ADDR_W.
//  DATA_W  8  ram data width.
//  HOLD    2  cycles ram_en_o is held high per access (latch-based cells need >=1); legal 1..15.
// PORTS
//  clk          in   1       rising-edge clock.
//  rst_n        in   1       synchronous active-low reset.
//  req_valid_i  in   2       per-port request; held high until that port's ack.
//  req_we_i     in   2       per-port: 1 = write, 0 = read.
//  req_addr0_i  in   ADDR_W  port 0 address.
//  req_addr1_i  in   ADDR_W  port 1 address.
//  req_wdata0_i in   DATA_W  port 0 write data.
//  req_wdata1_i in   DATA_W  port 1 write data.
//  ack_o        out  2       one-cycle completion pulse, one-hot or zero.
//  rdata_o      out  DATA_W  read data, valid while ack_o!=0 for a read; holds last value otherwise.
//  busy_o       out  1       high in ACCESS and DONE.
//  ram_en_o     out  1       to ram enRAM.
//  ram_rw_o     out  1       to ram RW; 1 = write.
//  ram_addr_o   out  ADDR_W  to ram address.
//  ram_wdata_o  out  DATA_W  to ram in.
//  ram_rdata_i  in   DATA_W  from ram out.
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, ack_o=0, rdata_o=0, busy_o=0, ram_en_o=0, ram_rw_o=0,
//   ram_addr_o=0, ram_wdata_o=0, last_grant=1 (port 0 wins first tie), hold counter=0.
//  FSM states: IDLE -> ACCESS -> DONE -> IDLE. All outputs registered.
//  IDLE: no valid -> stay. Valid seen at edge N -> grant chosen, addr/wdata/we latched into ram_*_o,
//   ram_en_o=1 from N+1, state=ACCESS.
//  Arbitration: one port valid -> it wins. Both valid -> port != last_grant wins; last_grant updated on grant.
//  ACCESS: ram_en_o=1 and ram_addr/wdata/rw stable for exactly HOLD cycles (N+1..N+HOLD).
//   On the last ACCESS edge, ram_rdata_i sampled into rdata_o (reads only), ram_en_o->0, state=DONE.
//  DONE: ack_o[grant]=1 for one cycle (N+HOLD+1); ram_en_o=0; request inputs ignored; next state IDLE.
//  Latency: valid sampled at N -> ack at N+HOLD+1; max throughput one access per HOLD+2 cycles.
//  Requester drops valid the cycle after ack; valid still high in the following IDLE = new request.
//  Loser's request is unaffected and is granted at the next IDLE.
//  Request inputs change outside IDLE sampling: ignored (latched copy used).
//  rdata_o unchanged by writes. Address wrap is not applicable (full 2**ADDR_W space, no increment).
//  Reset mid-ACCESS: ram_en_o drops at that edge, no ack issued; a write in flight leaves that
//   ram byte undefined. last_grant returns to 1.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: port 0 always wins ties (last_grant ignored; port 1 can starve).
//  Undefined (default): round-robin as above.
// TESTING
//  Reset: rst_n=0 2 cycles -> all outputs 0, busy_o=0.
//  Port 0 write addr 0x3C data 0xA5, HOLD=2 -> ram_en_o high 2 cycles, ram_rw_o=1, ack_o=01 at N+3.
//  Port 1 read 0x3C after that write -> ack_o=10, rdata_o=0xA5 during ack.
//  Both valid in same IDLE, repeated 4 accesses -> grants 0,1,0,1 (with ARB_FIXED_PRIO_EN: 0,0,0,0).
//  Write 0xFF to addr 0xFF then read it back -> 0xFF; addr 0x00 still 0x00.
//  rst_n low at second ACCESS cycle -> no ack, ram_en_o=0 next cycle, new request served normally.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: the single sequencer in front of the 256x8 ram block.
// It takes one request from one of two ports, holds the ram bus steady for
// HOLD enable cycles, captures the read data and returns a one-cycle ack.
// Ties are broken round-robin. Defining ARB_FIXED_PRIO_EN makes port 0
// always win ties, which lets port 1 starve.
module ram_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int HOLD   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid_i,
    input  logic [1:0]        req_we_i,
    input  logic [ADDR_W-1:0] req_addr0_i,
    input  logic [ADDR_W-1:0] req_addr1_i,
    input  logic [DATA_W-1:0] req_wdata0_i,
    input  logic [DATA_W-1:0] req_wdata1_i,
    output logic [1:0]        ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              ram_en_o,
    output logic              ram_rw_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter value on the final enable cycle of an access.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t            state, state_next;
    logic              grant, grant_next;
    logic              last_grant, last_grant_next;
    logic [3:0]        hold_cnt, hold_cnt_next;
    logic [1:0]        ack_next;
    logic [DATA_W-1:0] rdata_next;
    logic              busy_next;
    logic              en_next;
    logic              rw_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;
    logic              winner;

    // Pick the port that would be granted if a request is taken this cycle.
    always_comb begin
        winner = 1'b0;
        if (req_valid_i == 2'b10) begin
            winner = 1'b1;
        end else if (req_valid_i == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last_grant;
`endif
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        hold_cnt_next   = hold_cnt;
        ack_next        = 2'b00;
        rdata_next      = rdata_o;
        busy_next       = busy_o;
        en_next         = ram_en_o;
        rw_next         = ram_rw_o;
        addr_next       = ram_addr_o;
        wdata_next      = ram_wdata_o;
        case (state)
            IDLE: begin
                if (|req_valid_i) begin
                    grant_next      = winner;
                    last_grant_next = winner;
                    addr_next       = winner ? req_addr1_i : req_addr0_i;
                    wdata_next      = winner ? req_wdata1_i : req_wdata0_i;
                    rw_next         = req_we_i[winner];
                    en_next         = 1'b1;
                    busy_next       = 1'b1;
                    hold_cnt_next   = 4'd0;
                    state_next      = ACCESS;
                end
            end
            ACCESS: begin
                if (hold_cnt == HOLD_LAST) begin
                    en_next = 1'b0;
                    if (!ram_rw_o) begin
                        rdata_next = ram_rdata_i;
                    end
                    ack_next   = grant ? 2'b10 : 2'b01;
                    state_next = DONE;
                end else begin
                    hold_cnt_next = hold_cnt + 4'd1;
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                en_next    = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            hold_cnt    <= 4'd0;
            ack_o       <= 2'b00;
            rdata_o     <= '0;
            busy_o      <= 1'b0;
            ram_en_o    <= 1'b0;
            ram_rw_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            last_grant  <= last_grant_next;
            hold_cnt    <= hold_cnt_next;
            ack_o       <= ack_next;
            rdata_o     <= rdata_next;
            busy_o      <= busy_next;
            ram_en_o    <= en_next;
            ram_rw_o    <= rw_next;
            ram_addr_o  <= addr_next;
            ram_wdata_o <= wdata_next;
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: a behavioural ram, a reference memory and a
// round-robin arbitration model drive directed and random accesses.
module tb_ram_access_arbiter;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid_i;
    logic [1:0] req_we_i;
    logic [7:0] req_addr0_i, req_addr1_i;
    logic [7:0] req_wdata0_i, req_wdata1_i;
    logic [1:0] ack_o;
    logic [7:0] rdata_o;
    logic       busy_o;
    logic       ram_en_o;
    logic       ram_rw_o;
    logic [7:0] ram_addr_o;
    logic [7:0] ram_wdata_o;
    logic [7:0] ram_rdata_i;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] ram_mem [256];
    logic [7:0] ref_mem [256];
    int         model_last;
    logic [7:0] model_rdata;

    ram_access_arbiter #(.ADDR_W(8), .DATA_W(8), .HOLD(HOLD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid_i(req_valid_i),
        .req_we_i(req_we_i),
        .req_addr0_i(req_addr0_i),
        .req_addr1_i(req_addr1_i),
        .req_wdata0_i(req_wdata0_i),
        .req_wdata1_i(req_wdata1_i),
        .ack_o(ack_o),
        .rdata_o(rdata_o),
        .busy_o(busy_o),
        .ram_en_o(ram_en_o),
        .ram_rw_o(ram_rw_o),
        .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    // Behavioural ram: asynchronous read, write while enabled in write mode.
    assign ram_rdata_i = ram_mem[ram_addr_o];
    always @(posedge clk) begin
        if (ram_en_o && ram_rw_o) ram_mem[ram_addr_o] <= ram_wdata_o;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input bit we,
                                 input logic [7:0] addr, input logic [7:0] data);
        if (port == 0) begin
            req_addr0_i  = addr;
            req_wdata0_i = data;
        end else begin
            req_addr1_i  = addr;
            req_wdata1_i = data;
        end
        req_we_i[port]    = we;
        req_valid_i[port] = 1'b1;
    endtask

    // Reference arbitration: single requester wins; ties alternate
    // (or always go to port 0 in fixed-priority builds).
    function automatic int pickWinner(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef ARB_FIXED_PRIO_EN
        return 0;
`else
        return (model_last == 0) ? 1 : 0;
`endif
    endfunction

    // Runs one access from an idle DUT and checks bus, latency, ack and data.
    task automatic runAccess(input string tag, input bit keep_valid);
        int         w;
        bit         exp_we;
        logic [7:0] exp_addr, exp_wd, exp_rd;
        int         cyc = 0;
        int         en_cnt = 0;
        int         bus_bad = 0;
        bit         got = 0;
        w        = pickWinner(req_valid_i);
        exp_we   = req_we_i[w];
        exp_addr = (w == 1) ? req_addr1_i : req_addr0_i;
        exp_wd   = (w == 1) ? req_wdata1_i : req_wdata0_i;
        exp_rd   = exp_we ? model_rdata : ref_mem[exp_addr];
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (ram_en_o) begin
                en_cnt++;
                if (ram_addr_o !== exp_addr || ram_rw_o !== exp_we ||
                    (exp_we && ram_wdata_o !== exp_wd)) bus_bad++;
            end
            if (ack_o !== 2'b00) got = 1;
        end
        checkOutput({tag, "_ack_seen"}, 32'(got), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(HOLD + 1));
        checkOutput({tag, "_en_cycles"}, 32'(en_cnt), 32'(HOLD));
        checkOutput({tag, "_ram_bus"}, 32'(bus_bad), 32'd0);
        checkOutput({tag, "_ack"}, 32'(ack_o), (w == 1) ? 32'd2 : 32'd1);
        checkOutput({tag, "_rdata"}, 32'(rdata_o), 32'(exp_rd));
        model_last  = w;
        model_rdata = exp_rd;
        if (exp_we) ref_mem[exp_addr] = exp_wd;
        if (!keep_valid) req_valid_i[w] = 1'b0;
        tick();
        checkOutput({tag, "_ack_drop"}, 32'(ack_o), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        req_valid_i  = 2'b00;
        req_we_i     = 2'b00;
        req_addr0_i  = 8'h00;
        req_addr1_i  = 8'h00;
        req_wdata0_i = 8'h00;
        req_wdata1_i = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        model_last  = 1;
        model_rdata = 8'h00;

        // Reset for two cycles.
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_ack", 32'(ack_o), 32'd0);
        checkOutput("rst_rdata", 32'(rdata_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_en", 32'(ram_en_o), 32'd0);
        checkOutput("rst_rw", 32'(ram_rw_o), 32'd0);
        checkOutput("rst_addr", 32'(ram_addr_o), 32'd0);
        checkOutput("rst_wdata", 32'(ram_wdata_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Port 0 write then port 1 read of the same byte.
        applyStimulus(0, 1'b1, 8'h3C, 8'hA5);
        runAccess("p0_wr3c", 1'b0);
        applyStimulus(1, 1'b0, 8'h3C, 8'h00);
        runAccess("p1_rd3c", 1'b0);
        checkOutput("p1_rd3c_value", 32'(model_rdata), 32'hA5);

        // Both ports requesting continuously for four grants.
        applyStimulus(0, 1'b0, 8'h3C, 8'h11);
        applyStimulus(1, 1'b0, 8'h3C, 8'h22);
        for (int k = 0; k < 4; k++) begin
            int exp_w;
`ifdef ARB_FIXED_PRIO_EN
            exp_w = 0;
`else
            exp_w = k % 2;
`endif
            runAccess("tie", 1'b1);
            checkOutput("tie_order", 32'(model_last), 32'(exp_w));
        end
        req_valid_i = 2'b00;
        tick();

        // Top address write/readback; address 0 untouched.
        applyStimulus(0, 1'b1, 8'hFF, 8'hFF);
        runAccess("wr_ff", 1'b0);
        applyStimulus(1, 1'b0, 8'hFF, 8'h00);
        runAccess("rd_ff", 1'b0);
        checkOutput("rd_ff_value", 32'(rdata_o), 32'hFF);
        applyStimulus(0, 1'b0, 8'h00, 8'h00);
        runAccess("rd_00", 1'b0);
        checkOutput("rd_00_value", 32'(rdata_o), 32'h00);

        // Reset during the second ACCESS cycle of a read.
        applyStimulus(1, 1'b0, 8'h3C, 8'h00);
        tick();
        checkOutput("midrst_en1", 32'(ram_en_o), 32'd1);
        tick();
        checkOutput("midrst_en2", 32'(ram_en_o), 32'd1);
        rst_n = 1'b0;
        req_valid_i = 2'b00;
        tick();
        checkOutput("midrst_en_drop", 32'(ram_en_o), 32'd0);
        checkOutput("midrst_no_ack", 32'(ack_o), 32'd0);
        checkOutput("midrst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        model_last  = 1;
        model_rdata = 8'h00;
        tick();
        checkOutput("midrst_still_no_ack", 32'(ack_o), 32'd0);
        applyStimulus(0, 1'b0, 8'h3C, 8'h00);
        applyStimulus(1, 1'b0, 8'hFF, 8'h00);
        runAccess("post_rst_tie", 1'b0);
        checkOutput("post_rst_winner", 32'(model_last), 32'd0);
        req_valid_i = 2'b00;
        tick();

        // Random traffic against the reference memory and arbitration model.
        for (int n = 0; n < 40; n++) begin
            int mask;
            mask = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                if (mask[p]) applyStimulus(p, 1'($urandom_range(0, 1)),
                                           8'($urandom_range(0, 255)),
                                           8'($urandom_range(0, 255)));
            end
            runAccess("rand", 1'b0);
            req_valid_i = 2'b00;
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
